// File: rtl/fetch_ifu_if.sv
// rtl/fetch_ifu_if.sv - fetch unit handshake bundle: redirect, I-cache request/response, decode queue head
interface fetch_ifu_if #(
   parameter int XLEN = 32
);
   logic            redir_i;
   logic [XLEN-1:0] redir_pc_i;
   logic            ic_req_valid_o;
   logic            ic_req_ready_i;
   logic [XLEN-1:0] ic_req_addr_o;
   logic            ic_rsp_valid_i;
   logic [31:0]     ic_rsp_data_i;
   logic            ic_rsp_err_i;
   logic            id_valid_o;
   logic            id_ready_i;
   logic [31:0]     id_instr_o;
   logic [XLEN-1:0] id_pc_o;
   logic            id_err_o;

   // Fetch unit side
   modport master (
      input  redir_i, redir_pc_i,
      output ic_req_valid_o, ic_req_addr_o,
      input  ic_req_ready_i,
      input  ic_rsp_valid_i, ic_rsp_data_i, ic_rsp_err_i,
      output id_valid_o, id_instr_o, id_pc_o, id_err_o,
      input  id_ready_i
   );

   // Environment side: branch logic, I-cache and decode
   modport slave (
      output redir_i, redir_pc_i,
      input  ic_req_valid_o, ic_req_addr_o,
      output ic_req_ready_i,
      output ic_rsp_valid_i, ic_rsp_data_i, ic_rsp_err_i,
      input  id_valid_o, id_instr_o, id_pc_o, id_err_o,
      output id_ready_i
   );
endinterface

// File: rtl/fetch_ifu.sv
// rtl/fetch_ifu.sv - sequential instruction fetch with credit-limited I-cache requests and a fetch queue
module fetch_ifu #(
   parameter int              XLEN            = 32,
   parameter logic [XLEN-1:0] RESET_PC        = '0,
   parameter int              FQ_DEPTH        = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input logic         clk_i,
   input logic         rst_i,
   fetch_ifu_if.master bus
);
   localparam int PTR_W = $clog2(FQ_DEPTH);
   localparam int CNT_W = $clog2(FQ_DEPTH + 1);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  rsp_pc;
   logic [OUT_W-1:0] outstanding;
   logic [OUT_W-1:0] drop_cnt;
   logic             halted;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fq_count;

   logic [31:0]      fq_instr [FQ_DEPTH];
   logic [XLEN-1:0]  fq_pc    [FQ_DEPTH];
   logic             fq_err   [FQ_DEPTH];

   logic             credit_ok;
   logic             req_fire;
   logic             push;
   logic             pop;
   logic             head_valid;
   logic [XLEN-1:0]  redir_target;
   logic             unused_redir_lsbs;

   assign redir_target      = {bus.redir_pc_i[XLEN-1:2], 2'b00};
   assign unused_redir_lsbs = ^bus.redir_pc_i[1:0];

   // Queue slots already promised: occupied entries plus live (non-dropped) requests in flight
   always_comb begin
      credit_ok = (int'(fq_count) + int'(outstanding) - int'(drop_cnt)) < FQ_DEPTH;
   end

   assign bus.ic_req_valid_o = !rst_i && !bus.redir_i && !halted &&
                               (int'(outstanding) < MAX_OUTSTANDING) && credit_ok;
   assign bus.ic_req_addr_o  = fetch_pc;
   assign req_fire           = bus.ic_req_valid_o && bus.ic_req_ready_i;

   assign head_valid = (fq_count != '0);
   assign push       = bus.ic_rsp_valid_i && (drop_cnt == '0) && !bus.redir_i;
   assign pop        = head_valid && bus.id_ready_i && !bus.redir_i;

   // Head fields are forced to zero while empty so reset values need no reset on the storage
   assign bus.id_valid_o = head_valid;
   assign bus.id_instr_o = head_valid ? fq_instr[rd_ptr] : '0;
   assign bus.id_pc_o    = head_valid ? fq_pc[rd_ptr]    : '0;
   assign bus.id_err_o   = head_valid ? fq_err[rd_ptr]   : 1'b0;

   // Control state: PCs, in-flight/drop counters, halt flag and queue pointers; redirect overrides all
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         halted      <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fq_count    <= '0;
      end else if (bus.redir_i) begin
         fetch_pc    <= redir_target;
         rsp_pc      <= redir_target;
         halted      <= 1'b0;
         outstanding <= outstanding - OUT_W'(bus.ic_rsp_valid_i);
         drop_cnt    <= outstanding - OUT_W'(bus.ic_rsp_valid_i);
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fq_count    <= '0;
      end else begin
         if (req_fire) begin
            fetch_pc <= fetch_pc + XLEN'(4);
         end
         outstanding <= outstanding + OUT_W'(req_fire) - OUT_W'(bus.ic_rsp_valid_i);
         if (bus.ic_rsp_valid_i && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - OUT_W'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            rsp_pc <= rsp_pc + XLEN'(4);
            if (bus.ic_rsp_err_i) begin
               halted <= 1'b1;
            end
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         fq_count <= fq_count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Queue storage: written on live responses only
   always_ff @(posedge clk_i) begin
      if (push) begin
         fq_instr[wr_ptr] <= bus.ic_rsp_data_i;
         fq_pc[wr_ptr]    <= rsp_pc;
         fq_err[wr_ptr]   <= bus.ic_rsp_err_i;
      end
   end

   a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && (int'(fq_count) == FQ_DEPTH)));

   a_no_unexpected_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
      !(bus.ic_rsp_valid_i && (outstanding == '0)));
endmodule

// File: tb/tb_fetch_ifu.sv
// tb/tb_fetch_ifu.sv - scoreboard bench for fetch_ifu with a one-cycle in-order I-cache model
module tb_fetch_ifu;
   localparam int          XLEN     = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          FQ_DEPTH = 4;
   localparam int          MAX_OUT  = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } entry_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   fetch_ifu_if #(.XLEN(XLEN)) bus ();

   fetch_ifu #(
      .XLEN(XLEN), .RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   bit          rsp_en = 1'b1;
   logic [31:0] err_addr = 32'hFFFF_FFFF;

   entry_t      sb[$];
   logic [31:0] pending[$];
   logic [31:0] req_log[$];
   int          stale = 0;
   bit          halted_m = 1'b0;
   logic [31:0] exp_fetch = RESET_PC;
   int          req_total = 0;
   int          pop_total = 0;
   bit          first_pop_wait = 1'b1;
   logic [31:0] first_pop_pc = '0;
   bit          err_seen = 1'b0;
   logic [31:0] err_pop_pc = '0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
   endfunction

   // I-cache response driver: oldest pending request answered one per cycle
   initial begin
      bus.ic_rsp_valid_i = 1'b0;
      bus.ic_rsp_data_i  = '0;
      bus.ic_rsp_err_i   = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && rsp_en && pending.size() != 0) begin
            bus.ic_rsp_valid_i = 1'b1;
            bus.ic_rsp_data_i  = instr_of(pending[0]);
            bus.ic_rsp_err_i   = (pending[0] == err_addr);
         end else begin
            bus.ic_rsp_valid_i = 1'b0;
            bus.ic_rsp_data_i  = '0;
            bus.ic_rsp_err_i   = 1'b0;
         end
      end
   end

   // Monitor: checks head and requests against the model, then applies this cycle's events
   initial begin
      logic [31:0] a;
      entry_t      e;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete(); pending.delete(); req_log.delete();
            stale = 0; halted_m = 1'b0; exp_fetch = RESET_PC; first_pop_wait = 1'b1;
            continue;
         end
         checks++;
         if (bus.id_valid_o !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL head_valid: got %b want %b", bus.id_valid_o, (sb.size() != 0));
         end
         if (bus.id_valid_o === 1'b1 && sb.size() != 0) begin
            checks++;
            if (bus.id_pc_o !== sb[0].pc || bus.id_instr_o !== sb[0].instr || bus.id_err_o !== sb[0].err) begin
               errors++;
               $display("FAIL head_fields: got pc %h instr %h err %b want pc %h instr %h err %b",
                        bus.id_pc_o, bus.id_instr_o, bus.id_err_o, sb[0].pc, sb[0].instr, sb[0].err);
            end
         end
         if (bus.ic_req_valid_o && bus.ic_req_ready_i) begin
            checks++;
            if (bus.ic_req_addr_o !== exp_fetch || halted_m || bus.redir_i) begin
               errors++;
               $display("FAIL req_addr: got %h halted %b redir %b want %h", bus.ic_req_addr_o,
                        halted_m, bus.redir_i, exp_fetch);
            end
            pending.push_back(bus.ic_req_addr_o);
            req_log.push_back(bus.ic_req_addr_o);
            exp_fetch = exp_fetch + 32'd4;
            req_total++;
         end
         if (bus.id_valid_o && bus.id_ready_i && !bus.redir_i && sb.size() != 0) begin
            e = sb.pop_front();
            pop_total++;
            if (first_pop_wait) begin
               first_pop_pc   = e.pc;
               first_pop_wait = 1'b0;
            end
            if (e.err) begin
               err_seen   = 1'b1;
               err_pop_pc = e.pc;
            end
         end
         if (bus.ic_rsp_valid_i && pending.size() != 0) begin
            a = pending.pop_front();
            if (stale > 0) begin
               stale--;
            end else if (!bus.redir_i) begin
               e.pc = a; e.instr = instr_of(a); e.err = (a == err_addr);
               sb.push_back(e);
               if (e.err) halted_m = 1'b1;
            end
         end
         if (bus.redir_i) begin
            sb.delete();
            req_log.delete();
            stale          = pending.size();
            halted_m       = 1'b0;
            exp_fetch      = {bus.redir_pc_i[31:2], 2'b00};
            first_pop_wait = 1'b1;
         end
      end
   end

   task automatic redirect(input logic [31:0] target);
      @(posedge clk); #1;
      bus.redir_i = 1'b1; bus.redir_pc_i = target;
      @(posedge clk); #1;
      bus.redir_i = 1'b0;
   endtask

   task automatic wait_first_pop(input int budget, output bit ok);
      int n = 0;
      while (first_pop_wait && n < budget) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      ok = !first_pop_wait;
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (bus.ic_req_valid_o !== 1'b0 || bus.ic_req_addr_o !== RESET_PC || bus.id_valid_o !== 1'b0 ||
          bus.id_instr_o !== 32'h0 || bus.id_pc_o !== 32'h0 || bus.id_err_o !== 1'b0) begin
         errors++;
         $display("FAIL %s: got req_v %b addr %h id_v %b instr %h pc %h err %b want 0 %h 0 0 0 0", tag,
                  bus.ic_req_valid_o, bus.ic_req_addr_o, bus.id_valid_o, bus.id_instr_o, bus.id_pc_o,
                  bus.id_err_o, RESET_PC);
      end
   endtask

   task automatic check_first_request(input string tag);
      #1;
      checks++;
      if (bus.ic_req_valid_o !== 1'b1 || bus.ic_req_addr_o !== RESET_PC) begin
         errors++;
         $display("FAIL %s: got valid %b addr %h want 1 %h", tag, bus.ic_req_valid_o, bus.ic_req_addr_o, RESET_PC);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_values");
      @(posedge clk); #1;
      rst = 1'b0;
      check_first_request("first_request");
   endtask

   task automatic test_stream();
      int p0;
      bit ok;
      wait_first_pop(20, ok);
      checks++;
      if (!ok || first_pop_pc !== RESET_PC) begin
         errors++;
         $display("FAIL stream_first_pc: got %h ok %b want %h", first_pop_pc, ok, RESET_PC);
      end
      repeat (4) @(posedge clk);
      p0 = pop_total;
      repeat (10) @(posedge clk);
      checks++;
      if (pop_total - p0 != 10) begin
         errors++;
         $display("FAIL stream_throughput: got %0d want 10", pop_total - p0);
      end
   endtask

   task automatic test_backpressure();
      int r0;
      @(posedge clk); #1;
      bus.id_ready_i = 1'b0;
      redirect(32'h0000_0200);
      r0 = req_total;
      repeat (12) @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_total - r0 != FQ_DEPTH || bus.ic_req_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_requests: got %0d valid %b want %0d 0", req_total - r0, bus.ic_req_valid_o, FQ_DEPTH);
      end
      checks++;
      if (bus.id_valid_o !== 1'b1 || bus.id_pc_o !== 32'h0000_0200) begin
         errors++;
         $display("FAIL bp_head: got valid %b pc %h want 1 00000200", bus.id_valid_o, bus.id_pc_o);
      end
      @(posedge clk); #1;
      bus.id_ready_i = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.ic_req_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_same_cycle_credit: got %b want 0", bus.ic_req_valid_o);
      end
      @(negedge clk);
      checks++;
      if (bus.ic_req_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL bp_resume: got %b want 1", bus.ic_req_valid_o);
      end
      repeat (8) @(posedge clk);
   endtask

   task automatic test_redirect_inflight();
      bit ok;
      logic [31:0] first_req;
      @(posedge clk); #1;
      rsp_en = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if (pending.size() != MAX_OUT || bus.ic_req_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL inflight_limit: got %0d valid %b want %0d 0", pending.size(), bus.ic_req_valid_o, MAX_OUT);
      end
      redirect(32'h0000_1002);
      rsp_en = 1'b1;
      wait_first_pop(30, ok);
      first_req = (req_log.size() != 0) ? req_log[0] : 32'hDEAD_BEEF;
      checks++;
      if (!ok || first_pop_pc !== 32'h0000_1000 || first_req !== 32'h0000_1000) begin
         errors++;
         $display("FAIL inflight_redirect: got pop %h req %h ok %b want 00001000", first_pop_pc, first_req, ok);
      end
      repeat (5) @(posedge clk);
   endtask

   task automatic test_redirect_rsp();
      bit ok;
      repeat (4) @(posedge clk);
      @(posedge clk); #1;
      bus.redir_i = 1'b1; bus.redir_pc_i = 32'h0000_3000;
      @(posedge clk); #1;
      bus.redir_pc_i = 32'h0000_5000;
      @(posedge clk); #1;
      bus.redir_i = 1'b0;
      wait_first_pop(30, ok);
      checks++;
      if (!ok || first_pop_pc !== 32'h0000_5000) begin
         errors++;
         $display("FAIL double_redirect: got %h ok %b want 00005000", first_pop_pc, ok);
      end
      repeat (6) @(posedge clk);
   endtask

   task automatic test_fault();
      bit ok;
      err_seen = 1'b0;
      err_addr = 32'h0000_0008;
      redirect(32'h0000_0000);
      repeat (15) @(posedge clk);
      @(negedge clk);
      checks++;
      if (!err_seen || err_pop_pc !== 32'h0000_0008) begin
         errors++;
         $display("FAIL fault_decode: got seen %b pc %h want 1 00000008", err_seen, err_pop_pc);
      end
      checks++;
      if (bus.ic_req_valid_o !== 1'b0 || bus.id_valid_o !== 1'b0 || req_log.size() != 4) begin
         errors++;
         $display("FAIL fault_halt: got req_v %b id_v %b reqs %0d want 0 0 4", bus.ic_req_valid_o,
                  bus.id_valid_o, req_log.size());
      end
      err_addr = 32'hFFFF_FFFF;
      redirect(32'h0000_0040);
      wait_first_pop(30, ok);
      checks++;
      if (!ok || first_pop_pc !== 32'h0000_0040) begin
         errors++;
         $display("FAIL fault_resume: got %h ok %b want 00000040", first_pop_pc, ok);
      end
      repeat (4) @(posedge clk);
   endtask

   task automatic test_wrap();
      bit ok;
      logic [31:0] second_req;
      redirect(32'hFFFF_FFFC);
      wait_first_pop(30, ok);
      repeat (3) @(posedge clk);
      @(negedge clk);
      second_req = (req_log.size() >= 2) ? req_log[1] : 32'hDEAD_BEEF;
      checks++;
      if (!ok || first_pop_pc !== 32'hFFFF_FFFC || second_req !== 32'h0000_0000) begin
         errors++;
         $display("FAIL wrap: got pop %h next req %h ok %b want fffffffc 00000000", first_pop_pc, second_req, ok);
      end
   endtask

   task automatic test_async_reset();
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      check_first_request("post_reset_request");
      repeat (6) @(posedge clk);
   endtask

   initial begin
      bus.redir_i        = 1'b0;
      bus.redir_pc_i     = '0;
      bus.ic_req_ready_i = 1'b1;
      bus.id_ready_i     = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_inflight();
      test_redirect_rsp();
      test_fault();
      test_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1);
   end
endmodule
